// File: rtl/modacc_809.sv
// Purpose: streaming GF(809) frame accumulator; sums LEN residues mod 809 per frame (optional MODACC_RANGE_CHECK_EN adds err_range).
// Latency: out_valid rises the cycle after the final term of a frame is accepted.
// Backpressure: only the final term stalls, and only while the previous result is still unconsumed.
module modacc_809 #(
    parameter int LEN = 16,
    parameter int CW  = $clog2(LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [9:0]    in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [9:0]    out_data
`ifdef MODACC_RANGE_CHECK_EN
    ,
    output logic          err_range
`endif
);

    localparam logic [10:0]   MOD  = 11'd809;
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    logic [9:0]    acc;
    logic [CW-1:0] cnt;
    logic          is_final;
    logic          accept;
    logic [9:0]    term;
    logic [10:0]   sum;
    logic [9:0]    red;

`ifdef MODACC_RANGE_CHECK_EN
    logic          in_oor;
    assign in_oor = ({1'b0, in_data} >= MOD);
`endif

    assign is_final = (cnt == LAST);
    // The final term may not overwrite a result the consumer has not taken yet;
    // a same-cycle consume frees the register, so out_ready unblocks it directly.
    assign in_ready = !(is_final && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;

    // Add one term and fold back into 0..808 with a single conditional subtract;
    // both operands are below 809 so the sum never exceeds 1616.
    always_comb begin
        term = in_data;
`ifdef MODACC_RANGE_CHECK_EN
        if (in_oor) begin
            term = '0;
        end
`endif
        sum = {1'b0, acc} + {1'b0, term};
        if (sum >= MOD) begin
            red = 10'(sum - MOD);
        end else begin
            red = sum[9:0];
        end
    end

    // Accumulator and term counter: advance on every accepted term, clear at frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (is_final) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= red;
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Output register: load on final term (even during a consume), otherwise drop on consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept && is_final) begin
            out_valid <= 1'b1;
            out_data  <= red;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MODACC_RANGE_CHECK_EN
    // Sticky flag: any accepted out-of-range residue is remembered until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_range <= 1'b0;
        end else if (accept && in_oor) begin
            err_range <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_modacc_809.sv
// Purpose: directed self-checking bench for modacc_809 at LEN=4 (covers MODACC_RANGE_CHECK_EN when defined).
// Latency: inputs driven 1ns after the rising edge, outputs checked after settling.
// Backpressure: exercised by holding out_ready low across a completed frame.
module tb_modacc_809;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_data;
`ifdef MODACC_RANGE_CHECK_EN
    logic       err_range;
`endif

    int tests_run;
    int tests_failed;

    modacc_809 #(.LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef MODACC_RANGE_CHECK_EN
        ,
        .err_range (err_range)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; leave 1ns after the edge for driving and checking.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one term, confirm it will be taken, and clock it in (in_valid stays high).
    task automatic send(input logic [9:0] d, input string tag);
        in_valid = 1'b1;
        in_data  = d;
        #1;
        chk(tag, 16'(in_ready), 16'd1);
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset held for two cycles
        tick();
        tick();
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_out_data",  16'(out_data),  16'd0);
        chk("rst_in_ready",  16'(in_ready),  16'd1);
`ifdef MODACC_RANGE_CHECK_EN
        chk("rst_err_range", 16'(err_range), 16'd0);
`endif
        rst = 1'b0;

        // Wrap: 4 x 808 = 3232 = 3*809 + 805
        out_ready = 1'b1;
        send(10'd808, "wrap_rdy0");
        chk("wrap_no_early_valid", 16'(out_valid), 16'd0);
        send(10'd808, "wrap_rdy1");
        send(10'd808, "wrap_rdy2");
        send(10'd808, "wrap_rdy3");
        chk("wrap_valid", 16'(out_valid), 16'd1);
        chk("wrap_data",  16'(out_data),  16'd805);
        in_valid = 1'b0;
        tick();
        chk("wrap_valid_drop", 16'(out_valid), 16'd0);

        // Back-to-back frames with in_valid held high
        send(10'd1, "b2b_rdy_a0");
        send(10'd2, "b2b_rdy_a1");
        send(10'd3, "b2b_rdy_a2");
        send(10'd4, "b2b_rdy_a3");
        chk("b2b_valid_a", 16'(out_valid), 16'd1);
        chk("b2b_data_a",  16'(out_data),  16'd10);
        send(10'd0, "b2b_rdy_b0");
        chk("b2b_valid_consumed", 16'(out_valid), 16'd0);
        send(10'd0, "b2b_rdy_b1");
        send(10'd0, "b2b_rdy_b2");
        send(10'd0, "b2b_rdy_b3");
        chk("b2b_valid_b", 16'(out_valid), 16'd1);
        chk("b2b_data_b",  16'(out_data),  16'd0);
        in_valid = 1'b0;
        tick();
        chk("b2b_valid_drop", 16'(out_valid), 16'd0);

        // Backpressure: result 20 pending while next frame reaches its final term
        out_ready = 1'b0;
        send(10'd5, "bp_rdy0");
        send(10'd5, "bp_rdy1");
        send(10'd5, "bp_rdy2");
        send(10'd5, "bp_rdy3");
        chk("bp_valid_20", 16'(out_valid), 16'd1);
        chk("bp_data_20",  16'(out_data),  16'd20);
        send(10'd1, "bp_next_rdy0");
        send(10'd1, "bp_next_rdy1");
        send(10'd1, "bp_next_rdy2");
        in_valid = 1'b1;
        in_data  = 10'd1;
        #1;
        chk("bp_final_stalled", 16'(in_ready), 16'd0);
        tick();
        chk("bp_hold_valid",  16'(out_valid), 16'd1);
        chk("bp_hold_data",   16'(out_data),  16'd20);
        chk("bp_still_stall", 16'(in_ready),  16'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_unstall", 16'(in_ready), 16'd1);
        tick();
        chk("bp_new_valid", 16'(out_valid), 16'd1);
        chk("bp_new_data",  16'(out_data),  16'd4);
        in_valid = 1'b0;
        tick();
        chk("bp_drain", 16'(out_valid), 16'd0);

        // Mid-frame reset discards the partial sum of 7+7
        send(10'd7, "mid_rdy0");
        send(10'd7, "mid_rdy1");
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 16'(out_valid), 16'd0);
        chk("mid_rst_ready", 16'(in_ready),  16'd1);
        send(10'd1, "mid_rdy2");
        send(10'd2, "mid_rdy3");
        send(10'd3, "mid_rdy4");
        send(10'd4, "mid_rdy5");
        chk("mid_valid", 16'(out_valid), 16'd1);
        chk("mid_data",  16'(out_data),  16'd10);
        in_valid = 1'b0;
        tick();

`ifdef MODACC_RANGE_CHECK_EN
        // Out-of-range term counts but adds nothing; flag is sticky until reset
        chk("rc_err_before", 16'(err_range), 16'd0);
        send(10'd900, "rc_rdy0");
        chk("rc_err_set", 16'(err_range), 16'd1);
        send(10'd1, "rc_rdy1");
        send(10'd1, "rc_rdy2");
        send(10'd1, "rc_rdy3");
        chk("rc_valid", 16'(out_valid), 16'd1);
        chk("rc_data",  16'(out_data),  16'd3);
        in_valid = 1'b0;
        tick();
        tick();
        chk("rc_err_sticky", 16'(err_range), 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rc_err_cleared", 16'(err_range), 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
